ksa: RTL and testbench

- Key-scheduling stage of the ARC4 decryption datapath.
- Sits between the S-memory initialiser (which writes s[i]=i) and the PRGA stage inside arc4.
- On an en/rdy handshake it permutes the 256-byte S memory in place using the 24-bit key.
- Hands the permuted S memory to the PRGA stage, which the arc4 sequencer starts once ksa returns rdy.

---
 rtl/arc4_pkg.sv | 31 +++
 rtl/ksa.sv | 105 ++++++++++
 tb/tb_ksa.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/arc4_pkg.sv
// Shared ARC4 definitions: KSA state encoding, S-memory geometry and key byte
// selection used by the key-scheduling and cracker stages.
package arc4_pkg;

  localparam int KEY_W     = 24;
  localparam int KEY_BYTES = 3;
  localparam int S_DEPTH   = 256;
  localparam int ADDR_W    = 8;

  typedef enum logic [2:0] {
    IDLE,
    RD_SI,
    GET_SI,
    GET_SJ,
    WR_I,
    WR_J
  } ksa_state_t;

  // Key is consumed big-endian: sel 0 picks the most significant byte.
  function automatic logic [7:0] key_byte(input logic [KEY_W-1:0] k,
                                          input logic [1:0]       sel);
    logic [7:0] b;
    case (sel)
      2'd0:    b = k[23:16];
      2'd1:    b = k[15:8];
      default: b = k[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/ksa.sv
// ARC4 key-scheduling stage: permutes the 256-byte S memory in place using a
// 24-bit key, five cycles per index, handing off via an en/rdy handshake.
module ksa
  import arc4_pkg::*;
(
  input  logic             CLOCK_50,
  input  logic             rst_n,
  input  logic             en,
  output logic             rdy,
  input  logic [KEY_W-1:0] key,
  output logic [7:0]       s_addr,
  input  logic [7:0]       s_rddata,
  output logic [7:0]       s_wrdata,
  output logic             s_wren
);

  ksa_state_t       state, state_nx;
  logic [7:0]       i, j, si, sj;
  logic [1:0]       ksel;
  logic [KEY_W-1:0] key_q;
  logic [7:0]       jn;

  // s_rddata holds s[i] in GET_SI, so the new j is known in time to address s[j].
  assign jn = j + s_rddata + key_byte(key_q, ksel);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      state <= IDLE;
      i     <= '0;
      j     <= '0;
      ksel  <= '0;
      si    <= '0;
      sj    <= '0;
      key_q <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (en) begin
            key_q <= key;
            i     <= '0;
            j     <= '0;
            ksel  <= '0;
          end
        end
        GET_SI: begin
          si <= s_rddata;
          j  <= jn;
        end
        GET_SJ: sj <= s_rddata;
        WR_J: begin
          if (i != 8'hFF) begin
            i    <= i + 8'd1;
            ksel <= (ksel == 2'd2) ? 2'd0 : ksel + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: every output and the next state get a default first, so no path
  // through the case can leave a value held and infer a latch.
  always_comb begin
    state_nx = state;
    rdy      = 1'b0;
    s_addr   = '0;
    s_wrdata = '0;
    s_wren   = 1'b0;
    case (state)
      IDLE: begin
        rdy = 1'b1;
        if (en) state_nx = RD_SI;
      end
      RD_SI: begin
        s_addr   = i;
        state_nx = GET_SI;
      end
      GET_SI: begin
        s_addr   = jn;
        state_nx = GET_SJ;
      end
      GET_SJ: begin
        s_addr   = j;
        state_nx = WR_I;
      end
      WR_I: begin
        s_addr   = i;
        s_wrdata = sj;
        s_wren   = 1'b1;
        state_nx = WR_J;
      end
      WR_J: begin
        s_addr   = j;
        s_wrdata = si;
        s_wren   = 1'b1;
        state_nx = (i == 8'hFF) ? IDLE : RD_SI;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ksa.sv
// Directed bench for ksa: a behavioural S RAM (registered address, unregistered
// data), a reference KSA model, table-driven key vectors and corner sequences.
module tb_ksa;

  logic        CLOCK_50;
  logic        rst_n;
  logic        en;
  logic        rdy;
  logic [23:0] key;
  logic [7:0]  s_addr;
  logic [7:0]  s_rddata;
  logic [7:0]  s_wrdata;
  logic        s_wren;

  ksa dut (
    .CLOCK_50 (CLOCK_50),
    .rst_n    (rst_n),
    .en       (en),
    .rdy      (rdy),
    .key      (key),
    .s_addr   (s_addr),
    .s_rddata (s_rddata),
    .s_wrdata (s_wrdata),
    .s_wren   (s_wren)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  logic [7:0] mem [256];
  logic [7:0] addr_q;
  logic       do_init;

  always @(posedge CLOCK_50) begin
    if (do_init) begin
      for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
    end else if (s_wren) begin
      mem[s_addr] <= s_wrdata;
    end
    addr_q <= s_addr;
  end
  assign s_rddata = mem[addr_q];

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model of S.
  logic [7:0] model_s [256];

  task automatic model_reset();
    for (int k = 0; k < 256; k++) model_s[k] = 8'(k);
  endtask

  task automatic model_ksa(input logic [23:0] k);
    logic [7:0] jj, t, kb;
    jj = 8'd0;
    for (int ii = 0; ii < 256; ii++) begin
      case (ii % 3)
        0:       kb = k[23:16];
        1:       kb = k[15:8];
        default: kb = k[7:0];
      endcase
      jj = jj + model_s[ii] + kb;
      t = model_s[ii];
      model_s[ii] = model_s[jj];
      model_s[jj] = t;
    end
  endtask

  function automatic int s_diffs();
    int d = 0;
    for (int k = 0; k < 256; k++) if (mem[k] !== model_s[k]) d++;
    return d;
  endfunction

  task automatic init_mem();
    do_init = 1'b1;
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    do_init = 1'b0;
    model_reset();
  endtask

  // Per-job observations.
  logic [7:0] wr_a [512];
  logic [7:0] wr_d [512];
  int         nwr;
  int         busy;
  logic       accepted;

  // Entered and left on a negedge. disturb pulses en at busy cycles 10 and 700
  // and scrambles key right after acceptance.
  task automatic run_job(input logic [23:0] k, input bit keep_en, input bit disturb);
    en  = 1'b1;
    key = k;
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    en = keep_en;
    if (disturb) key = ~k;
    accepted = ~rdy;
    busy = 0;
    nwr  = 0;
    while (rdy == 1'b0 && busy < 2000) begin
      if (s_wren) begin
        if (nwr < 512) begin
          wr_a[nwr] = s_addr;
          wr_d[nwr] = s_wrdata;
        end
        nwr++;
      end
      busy++;
      en = keep_en || (disturb && (busy == 10 || busy == 700));
      @(negedge CLOCK_50);
    end
    if (busy >= 2000) check("job_timeout", 32'(busy), 32'd1280);
  endtask

  typedef struct packed {
    logic [23:0]     key;
    logic [2:0][7:0] jv;
    logic [2:0][7:0] wi;
    logic [2:0][7:0] wj;
  } vec_t;

  function automatic vec_t mk(input logic [23:0] k,
                              input logic [7:0] j0, j1, j2,
                              input logic [7:0] i0, i1, i2,
                              input logic [7:0] w0, w1, w2);
    vec_t v;
    v.key = k;
    v.jv[0] = j0; v.jv[1] = j1; v.jv[2] = j2;
    v.wi[0] = i0; v.wi[1] = i1; v.wi[2] = i2;
    v.wj[0] = w0; v.wj[1] = w1; v.wj[2] = w2;
    return v;
  endfunction

  vec_t vecs [3];
  int   wr_cnt;
  int   rdy_low;

  initial begin
    // Expected j, WR_I data and WR_J data for the first three iterations.
    vecs[0] = mk(24'h000000, 8'h00, 8'h01, 8'h03, 8'h00, 8'h01, 8'h03, 8'h00, 8'h01, 8'h02);
    vecs[1] = mk(24'h00033C, 8'h00, 8'h04, 8'h42, 8'h00, 8'h04, 8'h42, 8'h00, 8'h01, 8'h02);
    vecs[2] = mk(24'hFFFFFF, 8'hFF, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h01, 8'h02);

    rst_n   = 1'b0;
    en      = 1'b0;
    key     = '0;
    do_init = 1'b0;
    repeat (2) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    check("reset_rdy", 32'(rdy), 32'd1);
    check("reset_wren", 32'(s_wren), 32'd0);
    check("reset_addr", 32'(s_addr), 32'd0);
    check("reset_wrdata", 32'(s_wrdata), 32'd0);
    rst_n = 1'b1;

    wr_cnt = 0;
    rdy_low = 0;
    repeat (10) begin
      @(negedge CLOCK_50);
      if (s_wren) wr_cnt++;
      if (!rdy) rdy_low++;
    end
    check("idle_writes", 32'(wr_cnt), 32'd0);
    check("idle_rdy_low", 32'(rdy_low), 32'd0);

    for (int v = 0; v < 3; v++) begin
      init_mem();
      run_job(vecs[v].key, 1'b0, 1'b0);
      model_ksa(vecs[v].key);
      check($sformatf("v%0d_accept", v), 32'(accepted), 32'd1);
      check($sformatf("v%0d_busy", v), 32'(busy), 32'd1280);
      check($sformatf("v%0d_nwr", v), 32'(nwr), 32'd512);
      for (int n = 0; n < 3; n++) begin
        check($sformatf("v%0d_it%0d_i", v, n), 32'(wr_a[2*n]), 32'(n));
        check($sformatf("v%0d_it%0d_j", v, n), 32'(wr_a[2*n+1]), 32'(vecs[v].jv[n]));
        check($sformatf("v%0d_it%0d_wi", v, n), 32'(wr_d[2*n]), 32'(vecs[v].wi[n]));
        check($sformatf("v%0d_it%0d_wj", v, n), 32'(wr_d[2*n+1]), 32'(vecs[v].wj[n]));
      end
      check($sformatf("v%0d_last_i", v), 32'(wr_a[510]), 32'd255);
      check($sformatf("v%0d_s_diffs", v), 32'(s_diffs()), 32'd0);
    end

    // Busy-time en pulses and key changes must not disturb the job.
    init_mem();
    run_job(24'h00033C, 1'b0, 1'b1);
    model_ksa(24'h00033C);
    check("dist_busy", 32'(busy), 32'd1280);
    check("dist_s_diffs", 32'(s_diffs()), 32'd0);
    rdy_low = 0;
    repeat (3) begin
      @(negedge CLOCK_50);
      if (!rdy) rdy_low++;
    end
    check("dist_no_restart", 32'(rdy_low), 32'd0);

    // Reset 500 cycles into a job, with en also high to show reset wins.
    init_mem();
    en  = 1'b1;
    key = 24'h123456;
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    en = 1'b0;
    check("mid_started", 32'(rdy), 32'd0);
    repeat (499) @(negedge CLOCK_50);
    rst_n = 1'b0;
    en    = 1'b1;
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    check("mid_reset_rdy", 32'(rdy), 32'd1);
    check("mid_reset_wren", 32'(s_wren), 32'd0);
    check("mid_reset_addr", 32'(s_addr), 32'd0);
    rst_n = 1'b1;
    en    = 1'b0;
    init_mem();
    run_job(24'h000000, 1'b0, 1'b0);
    model_ksa(24'h000000);
    check("rerun_busy", 32'(busy), 32'd1280);
    check("rerun_s_diffs", 32'(s_diffs()), 32'd0);

    // en held across completion: the second job starts on the first rdy edge.
    init_mem();
    run_job(24'h0A0B0C, 1'b1, 1'b0);
    check("b2b_busy1", 32'(busy), 32'd1280);
    check("b2b_gap_rdy", 32'(rdy), 32'd1);
    run_job(24'h0A0B0C, 1'b0, 1'b0);
    check("b2b_accept2", 32'(accepted), 32'd1);
    check("b2b_busy2", 32'(busy), 32'd1280);
    model_ksa(24'h0A0B0C);
    model_ksa(24'h0A0B0C);
    check("b2b_s_diffs", 32'(s_diffs()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
